display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter TICK_COUNT, default 100000, gives the clk cycles per 1 ms tick.
REQ-002 Parameter HOLD_MS, default 500, gives the minimum ownership time in ms ticks before preemption; legal range 1..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req0, input, 1 bit: requester 0 asks for the display.
REQ-006 Port data0, input, 16 bits: requester 0 digits; [3:0] is digit 0 and [15:12] is digit 3.
REQ-007 Port req1, input, 1 bit: requester 1 asks for the display.
REQ-008 Port data1, input, 16 bits: requester 1 digits, same packing as data0.
REQ-009 Port gnt0, output, 1 bit, registered: requester 0 owns the display.
REQ-010 Port gnt1, output, 1 bit, registered: requester 1 owns the display.
REQ-011 Ports segment0, segment1, segment2 and segment3, output, 4 bits each, registered: digit codes for the downstream 4-digit seven-segment driver.
REQ-012 Port busy, output, 1 bit, registered: high when either grant is high.

Function
REQ-013 The FSM SHALL have three states: IDLE, OWN0 and OWN1; gnt0 is high only in OWN0, gnt1 is high only in OWN1, and the grants are never high together.
REQ-014 The last-owner pointer SHALL be 1 bit; it is updated on every entry to OWN0 or OWN1.
REQ-015 In IDLE, a single asserted request SHALL move the FSM to that requester's OWN state on the next edge.
- Latency: gnt is high one cycle after req is sampled high.
REQ-016 In IDLE with both requests asserted, the requester that is not the last owner SHALL win.
REQ-017 The ms prescaler SHALL count 0..TICK_COUNT-1 and emit a one-cycle tick at terminal count.
- The hold counter increments on each tick and saturates at HOLD_MS.
- Both the prescaler and the hold counter clear on every state change.
REQ-018 hold_done SHALL be defined as hold counter == HOLD_MS.
REQ-019 In OWN state x, if req_x is low:
- go to the other OWN state if the other request is high;
- otherwise go to IDLE.
REQ-020 In OWN state x, with req_x high, the other request high and hold_done high, the FSM SHALL move to the other OWN state (round-robin preemption).
REQ-021 In OWN state x, with req_x high and either hold_done low or the other request low, the FSM SHALL stay in OWN x indefinitely.
REQ-022 The segment outputs SHALL be reloaded every cycle from the registered next state:
- OWN0: segmentN = data0 nibble N;
- OWN1: segmentN = data1 nibble N;
- IDLE: all four outputs = 4'hF (blank code).
- The segment outputs therefore change on the same edge as the grants, and data changes during ownership appear one cycle later.
REQ-023 Switch-over SHALL be a direct OWN0<->OWN1 transition: no IDLE gap cycle and no cycle with both grants high.
REQ-024 If the owner drops req on the same cycle that preemption would fire, REQ-019 SHALL take precedence; the result is the same next state.
REQ-025 No request SHALL be starved: with both requests held high continuously, ownership alternates every HOLD_MS ticks plus at most one cycle.

Reset
REQ-026 While reset is high at a clk edge, the block SHALL load:
- state = IDLE;
- gnt0 = gnt1 = busy = 0;
- segment0..3 = 4'hF;
- prescaler = hold counter = 0;
- last-owner pointer = 1, so requester 0 wins the first contention.
REQ-027 Reset SHALL override every other transition, including a reset asserted mid-ownership.
- Grants drop on the edge at which reset is sampled.
- The first grant after reset release is issued no earlier than one cycle after release.

Verification (TICK_COUNT=4, HOLD_MS=3)
REQ-028 Reset then idle -> gnt0=gnt1=busy=0 and segment0..3=4'hF.
REQ-029 req0=1 with data0=16'h1234 -> the next cycle shows gnt0=1, busy=1, segment3..0=1,2,3,4; changing data0 to 16'h5678 updates the segments one cycle later.
REQ-030 req0 and req1 rise together after reset with data1=16'h9876 -> gnt0 first; gnt1 is granted exactly 12 cycles after the gnt0 grant cycle (+1 registration), with segments switching to 9,8,7,6 on the same edge; gnt0 is regranted after a further 12 cycles.
REQ-031 gnt1 owner drops req1 while req0 is high and hold_done is low -> OWN0 on the next edge, no IDLE cycle, grants never overlap; then req0 drops with req1 low -> IDLE and blank segments.
REQ-032 reset asserted for 1 cycle while OWN1 with hold partially counted, both reqs held high -> IDLE on that edge; after release gnt0 wins (pointer=1) and the hold count restarts from 0.
REQ-033 req1 alone held 40 cycles -> gnt1 stays high throughout and the hold counter saturates at 3 without wrapping.

Source files
------------

// File: rtl/display_arbiter.sv
// Two-requester arbiter for a shared 4-digit seven-segment display.
// The owner keeps the display for at least HOLD_MS ms ticks before the other
// requester can take it.
//
// state | meaning
// IDLE  | nobody owns the display, segments blank
// OWN0  | requester 0 owns the display, segments show data0
// OWN1  | requester 1 owns the display, segments show data1
module display_arbiter #(
  parameter int TICK_COUNT = 100000,
  parameter int HOLD_MS    = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  segment0,
  output logic [3:0]  segment1,
  output logic [3:0]  segment2,
  output logic [3:0]  segment3,
  output logic        busy
);

  localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
  localparam logic [15:0]   HOLD_MAX   = 16'(HOLD_MS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc_cnt;
  logic [15:0]   hold_cnt;
  logic          last_owner;
  logic          tick;
  logic          hold_done;

  assign tick      = (presc_cnt == PRESC_LAST);
  assign hold_done = (hold_cnt == HOLD_MAX);

  // Next-state: a dropped owner request always wins over preemption.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
        else              state_nxt = IDLE;
      end
      OWN0: begin
        if (!req0)                 state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && hold_done) state_nxt = OWN1;
        else                       state_nxt = OWN0;
      end
      OWN1: begin
        if (!req1)                 state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && hold_done) state_nxt = OWN0;
        else                       state_nxt = OWN1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, timers, owner pointer and registered outputs driven from state_nxt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc_cnt  <= '0;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
      segment0   <= 4'hF;
      segment1   <= 4'hF;
      segment2   <= 4'hF;
      segment3   <= 4'hF;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        presc_cnt <= '0;
        hold_cnt  <= '0;
        if (state_nxt == OWN0)      last_owner <= 1'b0;
        else if (state_nxt == OWN1) last_owner <= 1'b1;
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (tick && !hold_done) hold_cnt <= hold_cnt + 16'd1;
      end
      gnt0 <= (state_nxt == OWN0);
      gnt1 <= (state_nxt == OWN1);
      busy <= (state_nxt != IDLE);
      unique case (state_nxt)
        OWN0: begin
          segment0 <= data0[3:0];
          segment1 <= data0[7:4];
          segment2 <= data0[11:8];
          segment3 <= data0[15:12];
        end
        OWN1: begin
          segment0 <= data1[3:0];
          segment1 <= data1[7:4];
          segment2 <= data1[11:8];
          segment3 <= data1[15:12];
        end
        default: begin
          segment0 <= 4'hF;
          segment1 <= 4'hF;
          segment2 <= 4'hF;
          segment3 <= 4'hF;
        end
      endcase
    end
  end

endmodule
